// File: rtl/mem_arbiter_pkg.sv
// Shared sizing, state encoding and controller request record for mem_arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_W           = 32;
    localparam int DATA_W           = 32;
    localparam int LEN_W            = 3;
    localparam int DEF_STARVE_LIMIT = 4;

    // Instruction fetches are always full-word reads.
    localparam logic [LEN_W-1:0] IF_LEN = 3'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2,
        DRAIN   = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] wdata;
    } mc_req_t;

    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter in front of a single memory controller.
// Define MEM_ARB_RR_EN for strict round-robin instead of LSB priority with a starvation limit.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_data,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [LEN_W-1:0]  ls_len,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mc_en,
    output logic              mc_wr,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [LEN_W-1:0]  mc_len,
    output logic [DATA_W-1:0] mc_wdata,
    input  logic              mc_done,
    input  logic [DATA_W-1:0] mc_rdata
);

    arb_state_e        state_q, state_d;
    mc_req_t           mc_q, mc_d;
    logic              mc_en_q, mc_en_d;
    logic              if_done_q, if_done_d;
    logic              ls_done_q, ls_done_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

    logic grant_ok;
    logic grant_if;
    logic grant_ls;
    logic flush;

`ifdef MEM_ARB_RR_EN
    logic last_if_q, last_if_d;
`else
    localparam int CNT_W = cnt_width(STARVE_LIMIT);
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             starve_hit;

    assign starve_hit = (starve_q == CNT_W'(STARVE_LIMIT));
`endif

    // No grant while frozen, flushing, or while a done pulse gives the requester its turnaround cycle.
    assign grant_ok = (state_q == IDLE) && rdy && !rollback && !if_done_q && !ls_done_q;

    always_comb begin : grant_select
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (grant_ok) begin
`ifdef MEM_ARB_RR_EN
            grant_if = if_req && (!ls_req || !last_if_q);
`else
            grant_if = if_req && (!ls_req || starve_hit);
`endif
            grant_ls = ls_req && !grant_if;
        end
    end

    // Stores cannot be abandoned once issued; fetches and loads can.
    assign flush = rollback &&
                   ((state_q == BUSY_IF) || ((state_q == BUSY_LS) && !mc_q.wr));

`ifdef MEM_ARB_RR_EN
    always_comb begin : rr_next
        last_if_d = last_if_q;
        if (grant_if) begin
            last_if_d = 1'b1;
        end else if (grant_ls) begin
            last_if_d = 1'b0;
        end
    end
`else
    always_comb begin : starve_next
        starve_d = starve_q;
        if (rdy) begin
            if (!if_req || grant_if) begin
                starve_d = '0;
            end else if (grant_ls && !starve_hit) begin
                starve_d = starve_q + CNT_W'(1);
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin : state_reg
        if (rst) begin
            state_q    <= IDLE;
            mc_q       <= '0;
            mc_en_q    <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_if_q  <= 1'b0;
`else
            starve_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            mc_q       <= mc_d;
            mc_en_q    <= mc_en_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_if_q  <= last_if_d;
`else
            starve_q   <= starve_d;
`endif
        end
    end

    always_comb begin : state_next
        state_d = state_q;
        if (rdy) begin
            unique case (state_q)
                IDLE: begin
                    if (grant_if) begin
                        state_d = BUSY_IF;
                    end else if (grant_ls) begin
                        state_d = BUSY_LS;
                    end
                end
                BUSY_IF, BUSY_LS: begin
                    if (mc_done) begin
                        state_d = IDLE;
                    end else if (flush) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (mc_done) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin : output_next
        mc_d       = mc_q;
        mc_en_d    = mc_en_q;
        if_done_d  = if_done_q;
        ls_done_d  = ls_done_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        if (rdy) begin
            if_done_d = 1'b0;
            ls_done_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant_if) begin
                        mc_d.wr    = 1'b0;
                        mc_d.addr  = if_addr;
                        mc_d.len   = IF_LEN;
                        mc_d.wdata = '0;
                        mc_en_d    = 1'b1;
                    end else if (grant_ls) begin
                        mc_d.wr    = ls_wr;
                        mc_d.addr  = ls_addr;
                        mc_d.len   = ls_len;
                        mc_d.wdata = ls_wdata;
                        mc_en_d    = 1'b1;
                    end
                end
                BUSY_IF: begin
                    if (mc_done) begin
                        mc_en_d = 1'b0;
                        if (!flush) begin
                            if_done_d = 1'b1;
                            if_data_d = mc_rdata;
                        end
                    end
                end
                BUSY_LS: begin
                    if (mc_done) begin
                        mc_en_d = 1'b0;
                        if (!flush) begin
                            ls_done_d  = 1'b1;
                            ls_rdata_d = mc_rdata;
                        end
                    end
                end
                DRAIN: begin
                    if (mc_done) begin
                        mc_en_d = 1'b0;
                    end
                end
                default: mc_en_d = 1'b0;
            endcase
        end
    end

    assign mc_en    = mc_en_q;
    assign mc_wr    = mc_q.wr;
    assign mc_addr  = mc_q.addr;
    assign mc_len   = mc_q.len;
    assign mc_wdata = mc_q.wdata;
    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;

endmodule
